// File: rtl/mult42_seq_ctrl.sv
// Iterative unsigned multiplier: folds two partial products per cycle through one
// row of 4-2 compressors, then resolves the redundant sum/carry pair with one add.

module compressor (
  input  logic x1,
  input  logic x2,
  input  logic x3,
  input  logic x4,
  input  logic cin,
  output logic s,
  output logic carry,
  output logic cout
);
  logic t_s;

  // cout never depends on cin, so a row of these has no ripple path
  assign t_s   = x1 ^ x2 ^ x3;
  assign cout  = (x1 & x2) | (x1 & x3) | (x2 & x3);
  assign s     = t_s ^ x4 ^ cin;
  assign carry = (t_s & x4) | (t_s & cin) | (x4 & cin);
endmodule

module mult42_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);
  localparam int PW   = 2 * WIDTH;
  localparam int HALF = WIDTH / 2;
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(HALF - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_COMPRESS = 2'd1,
    S_FINAL    = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [PW-1:0]   sum_q, sum_d, carry_q, carry_d;
  logic [PW-1:0]   product_q, product_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;
  logic            in_ready_q, in_ready_d;

  logic [CW:0]     idx_lo_s, idx_hi_s;
  logic [PW-1:0]   a_ext_s, pp_lo_s, pp_hi_s;
  logic [PW-1:0]   s_s, carry_out_s, cout_s, cin_s;

  // partial products for the current pair of multiplier bits
  always_comb begin
    idx_lo_s = {cnt_q, 1'b0};
    idx_hi_s = {cnt_q, 1'b1};
    a_ext_s  = {{WIDTH{1'b0}}, a_q};
    if (b_q[idx_lo_s]) begin
      pp_lo_s = a_ext_s << idx_lo_s;
    end else begin
      pp_lo_s = {PW{1'b0}};
    end
    if (b_q[idx_hi_s]) begin
      pp_hi_s = a_ext_s << idx_hi_s;
    end else begin
      pp_hi_s = {PW{1'b0}};
    end
  end

  // shift drops the MSB cout, keeping arithmetic mod 2^PW
  assign cin_s = cout_s << 1;

  for (genvar i = 0; i < PW; i++) begin : g_row
    compressor u_cmp (
      .x1    (sum_q[i]),
      .x2    (carry_q[i]),
      .x3    (pp_lo_s[i]),
      .x4    (pp_hi_s[i]),
      .cin   (cin_s[i]),
      .s     (s_s[i]),
      .carry (carry_out_s[i]),
      .cout  (cout_s[i])
    );
  end

  // next-state and datapath updates
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    product_d = product_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          sum_d   = {PW{1'b0}};
          carry_d = {PW{1'b0}};
          cnt_d   = {CW{1'b0}};
          state_d = S_COMPRESS;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_COMPRESS: begin
        sum_d   = s_s;
        carry_d = carry_out_s << 1;
        if (cnt_q == LAST_CNT) begin
          state_d = S_FINAL;
        end else begin
          cnt_d = cnt_q + CW'(1'b1);
        end
      end
      S_FINAL: begin
        product_d = sum_q + carry_q;
        state_d   = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d  = (state_d == S_IDLE);
    busy_d      = (state_d == S_COMPRESS) || (state_d == S_FINAL);
    out_valid_d = (state_d == S_DONE);
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= {CW{1'b0}};
      a_q         <= {WIDTH{1'b0}};
      b_q         <= {WIDTH{1'b0}};
      sum_q       <= {PW{1'b0}};
      carry_q     <= {PW{1'b0}};
      product_q   <= {PW{1'b0}};
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      product_q   <= product_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign product   = product_q;
endmodule

// File: tb/tb_mult42_seq_ctrl.sv
// Directed and randomized checks of mult42_seq_ctrl (WIDTH=8 and WIDTH=4 instances)
// against plain a*b arithmetic and an in-order queue of expected products.

module tb_mult42_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [7:0]  a, b;
  logic [15:0] product;

  logic        in_valid4, in_ready4, out_valid4, out_ready4, busy4;
  logic [3:0]  a4, b4;
  logic [7:0]  product4;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  mult42_seq_ctrl #(.WIDTH(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .busy(busy)
  );

  mult42_seq_ctrl #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .out_valid(out_valid4), .out_ready(out_ready4),
    .product(product4), .busy(busy4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_v, input string tag);
    int lat;
    int guard;
    logic [31:0] expv;
    expv  = 32'(ta) * 32'(tb_v);
    guard = 0;
    while (!in_ready && guard < 50) begin
      step();
      guard++;
    end
    a = ta;
    b = tb_v;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      step();
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'd5);
    chk({tag, " product"}, 32'(product), expv);
    out_ready = 1'b1;
    step();
    chk({tag, " in_ready after"}, 32'(in_ready), 32'd1);
    chk({tag, " out_valid after"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int lat;
    int ov_seen;
    int acc_n;
    int res_n;
    int cyc;

    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; a = 8'h00; b = 8'h00;
    in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = 4'h0; b4 = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset product", 32'(product), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    out_ready = 1'b1;
    do_op(8'hFF, 8'hFF, "ff_x_ff");
    do_op(8'h00, 8'hA5, "zero_a");
    do_op(8'h37, 8'h00, "zero_b");
    do_op(8'h80, 8'h80, "msb_x_msb");

    // WIDTH=4 instance
    a4 = 4'hF; b4 = 4'hF; in_valid4 = 1'b1; out_ready4 = 1'b1;
    step();
    in_valid4 = 1'b0;
    lat = 0;
    while (!out_valid4 && lat < 50) begin
      step();
      lat++;
    end
    chk("w4 latency", 32'(lat), 32'd3);
    chk("w4 product", 32'(product4), 32'h0000_00E1);
    step();
    chk("w4 in_ready after", 32'(in_ready4), 32'd1);

    // backpressure with ignored input pulses
    out_ready = 1'b0;
    a = 8'h12; b = 8'h34; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      step();
      lat++;
    end
    chk("bp latency", 32'(lat), 32'd5);
    for (int i = 0; i < 10; i++) begin
      chk("bp product", 32'(product), 32'h0000_03A8);
      chk("bp in_ready", 32'(in_ready), 32'd0);
      chk("bp out_valid", 32'(out_valid), 32'd1);
      a = 8'($urandom); b = 8'($urandom); in_valid = i[0];
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp release in_ready", 32'(in_ready), 32'd1);
    chk("bp release out_valid", 32'(out_valid), 32'd0);
    chk("bp held product", 32'(product), 32'h0000_03A8);

    // reset in the middle of a compress phase
    a = 8'hAB; b = 8'hCD; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("midop busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst in_ready", 32'(in_ready), 32'd1);
    chk("async rst busy", 32'(busy), 32'd0);
    chk("async rst out_valid", 32'(out_valid), 32'd0);
    chk("async rst product", 32'(product), 32'd0);
    step();
    @(negedge clk);
    rst_n = 1'b1;
    ov_seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (out_valid) ov_seen++;
    end
    chk("no out_valid after abort", 32'(ov_seen), 32'd0);
    do_op(8'd3, 8'd5, "post_reset");

    // streaming random operands with random backpressure
    acc_n = 0;
    res_n = 0;
    cyc   = 0;
    while ((acc_n < 1000 || exp_q.size() != 0) && cyc < 30000) begin
      a = 8'($urandom);
      b = 8'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      in_valid = (acc_n < 1000);
      if (in_valid && in_ready) begin
        exp_q.push_back({8'h00, a} * {8'h00, b});
        acc_n++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("b2b spurious result", 32'd1, 32'd0);
        end else begin
          chk("b2b product", 32'(product), 32'(exp_q.pop_front()));
        end
        res_n++;
      end
      step();
      cyc++;
    end
    in_valid = 1'b0;
    chk("b2b result count", 32'(res_n), 32'd1000);
    chk("b2b leftover", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
